// File: rtl/board_seeder.sv
// board_seeder
// Fills the Game-of-Life current-state board RAM with an initial pattern.
// When a fill runs, every cell is written in row-major order at one cell per
// clock. The pattern is all-dead, a single glider, or pseudo-random live
// cells taken from a 16-bit Galois LFSR. The block also holds the evolution
// stage off through hold_evo while a fill runs.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      fill request, sampled only in IDLE
//   mode       0 clear, 1 glider, 2 random, 3 clear; latched with start
//   seed_load  load seed_in into the LFSR (IDLE only; 0 maps to SEED)
//   seed_in    new LFSR seed
//   ram_wren   board RAM write enable
//   ram_addr   write address, row*N + col
//   ram_data   cell value, 1 = live
//   busy       high while writing
//   done       one-cycle pulse after the last write
//   hold_evo   high while busy and during the done cycle
module board_seeder #(
    parameter int          P_PARAM_N  = 40,
    parameter int          P_PARAM_M  = 30,
    parameter int          ADDR_WIDTH = 24,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [8:0]  DENSITY    = 9'd64,
    parameter int          AUTO_START = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  seed_load,
    input  logic [15:0]           seed_in,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  busy,
    output logic                  done,
    output logic                  hold_evo
);

    localparam int unsigned CELLS = P_PARAM_N * P_PARAM_M;
    localparam int CW = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
    localparam int RW = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELLS - 1);
    localparam logic [CW-1:0]         COL_MAX   = CW'(P_PARAM_N - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;     // column of the next cell to write
    logic [RW-1:0]           row_q, row_d;     // row of the next cell to write
    logic [15:0]             lfsr_q, lfsr_d;   // value consumed by the next write
    logic [1:0]              mode_q, mode_d;
    logic                    auto_q, auto_d;   // pending automatic fill after reset
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wren_q, wren_d;
    logic                    data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hold_q, hold_d;

    // Cell about to be written this cycle (either the first cell on FILL
    // entry, or the next one during FILL).
    logic                    issue;
    logic [CW-1:0]           cur_col;
    logic [RW-1:0]           cur_row;
    logic [15:0]             cur_lfsr;
    logic [1:0]              cur_mode;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Row/col are compared in 32-bit space so narrow counters on tiny
    // boards cannot alias onto glider coordinates that do not exist.
    function automatic logic cell_val(input logic [1:0]    md,
                                      input logic [RW-1:0] r,
                                      input logic [CW-1:0] c,
                                      input logic [7:0]    lo);
        int unsigned ri;
        int unsigned ci;
        logic        v;
        ri = 32'(r);
        ci = 32'(c);
        case (md)
            2'd1:    v = (ri == 1 && ci == 2) || (ri == 2 && ci == 3) ||
                         (ri == 3 && ci >= 1 && ci <= 3);
            2'd2:    v = ({1'b0, lo} < DENSITY);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        lfsr_d   = lfsr_q;
        mode_d   = mode_q;
        auto_d   = auto_q;
        addr_d   = '0;
        wren_d   = 1'b0;
        data_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        hold_d   = 1'b0;
        issue    = 1'b0;
        cur_col  = col_q;
        cur_row  = row_q;
        cur_lfsr = lfsr_q;
        cur_mode = mode_q;

        case (state_q)
            S_IDLE: begin
                if (seed_load)
                    lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
                if (start || auto_q) begin
                    mode_d   = auto_q ? 2'd2 : mode;
                    auto_d   = 1'b0;
                    state_d  = S_FILL;
                    // First write goes out next cycle, so it is computed now,
                    // with any seed loaded in this same cycle.
                    issue    = 1'b1;
                    cur_col  = '0;
                    cur_row  = '0;
                    cur_lfsr = lfsr_d;
                    cur_mode = mode_d;
                    addr_d   = '0;
                end
            end
            S_FILL: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b1;
                end else begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            wren_d = 1'b1;
            busy_d = 1'b1;
            hold_d = 1'b1;
            data_d = cell_val(cur_mode, cur_row, cur_col, cur_lfsr[7:0]);
            lfsr_d = lfsr_step(cur_lfsr);
            if (cur_col == COL_MAX) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lfsr_q  <= SEED;
            mode_q  <= 2'd0;
            auto_q  <= (AUTO_START != 0);
            addr_q  <= '0;
            wren_q  <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            auto_q  <= auto_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign ram_wren = wren_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hold_evo = hold_q;

endmodule

// File: tb/tb_board_seeder.sv
// Bench for board_seeder: three instances (4x3 dense, 5x5 sparse, default
// 40x30 with auto start) each checked every cycle against a behavioural
// model that tracks the fill as a running cell index.
module tb_board_seeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i   [3];
    logic        start_i [3];
    logic [1:0]  mode_i  [3];
    logic        sl_i    [3];
    logic [15:0] seed_i  [3];
    logic        wren_o  [3];
    logic [23:0] addr_o  [3];
    logic        data_o  [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        hold_o  [3];

    board_seeder #(.P_PARAM_N(4), .P_PARAM_M(3), .DENSITY(9'd256), .AUTO_START(0)) u0 (
        .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .mode(mode_i[0]),
        .seed_load(sl_i[0]), .seed_in(seed_i[0]), .ram_wren(wren_o[0]),
        .ram_addr(addr_o[0]), .ram_data(data_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .hold_evo(hold_o[0]));

    board_seeder #(.P_PARAM_N(5), .P_PARAM_M(5), .DENSITY(9'd0), .AUTO_START(0)) u1 (
        .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .mode(mode_i[1]),
        .seed_load(sl_i[1]), .seed_in(seed_i[1]), .ram_wren(wren_o[1]),
        .ram_addr(addr_o[1]), .ram_data(data_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .hold_evo(hold_o[1]));

    board_seeder u2 (
        .clk(clk), .rst(rst_i[2]), .start(start_i[2]), .mode(mode_i[2]),
        .seed_load(sl_i[2]), .seed_in(seed_i[2]), .ram_wren(wren_o[2]),
        .ram_addr(addr_o[2]), .ram_data(data_o[2]), .busy(busy_o[2]),
        .done(done_o[2]), .hold_evo(hold_o[2]));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // per-instance observations of the DUT
    int          nwr   [3];
    int          nones [3];
    int          ndone [3];
    logic [7:0]  first8[3];
    logic [63:0] mask  [3];

    // behavioural model
    int          m_ph  [3];   // 0 idle, 1 writing, 2 done cycle
    int          m_k   [3];   // index of the cell being written
    bit          m_auto[3];
    logic [15:0] m_lfsr[3];
    logic [1:0]  m_md  [3];
    int          m_ones[3];
    logic        e_wren[3], e_data[3], e_busy[3], e_done[3], e_hold[3];
    logic [23:0] e_addr[3];

    function automatic int nn(input int i);
        return (i == 0) ? 4 : (i == 1) ? 5 : 40;
    endfunction
    function automatic int mm(input int i);
        return (i == 0) ? 3 : (i == 1) ? 5 : 30;
    endfunction
    function automatic int dens(input int i);
        return (i == 0) ? 256 : (i == 1) ? 0 : 64;
    endfunction
    function automatic bit aut(input int i);
        return (i == 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic emit(input int i);
        int r;
        int c;
        logic d;
        r = m_k[i] / nn(i);
        c = m_k[i] % nn(i);
        if (m_md[i] == 2'd1)
            d = (r == 1 && c == 2) || (r == 2 && c == 3) || (r == 3 && c >= 1 && c <= 3);
        else if (m_md[i] == 2'd2)
            d = (int'(m_lfsr[i][7:0]) < dens(i));
        else
            d = 1'b0;
        m_lfsr[i] = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 16'hB400) : (m_lfsr[i] >> 1);
        if (d) m_ones[i]++;
        e_wren[i] = 1'b1; e_busy[i] = 1'b1; e_hold[i] = 1'b1;
        e_data[i] = d;    e_addr[i] = 24'(m_k[i]);
    endtask

    task automatic model_step(input int i);
        e_wren[i] = 1'b0; e_data[i] = 1'b0; e_busy[i] = 1'b0;
        e_done[i] = 1'b0; e_hold[i] = 1'b0; e_addr[i] = '0;
        if (rst_i[i]) begin
            m_ph[i] = 0; m_k[i] = 0; m_lfsr[i] = 16'hACE1; m_auto[i] = aut(i);
        end else if (m_ph[i] == 0) begin
            if (sl_i[i]) m_lfsr[i] = (seed_i[i] == 16'h0) ? 16'hACE1 : seed_i[i];
            if (start_i[i] || m_auto[i]) begin
                m_md[i] = m_auto[i] ? 2'd2 : mode_i[i];
                m_auto[i] = 1'b0;
                m_ph[i] = 1; m_k[i] = 0;
                emit(i);
            end
        end else if (m_ph[i] == 1) begin
            if (m_k[i] == nn(i) * mm(i) - 1) begin
                m_ph[i] = 2; e_done[i] = 1'b1; e_hold[i] = 1'b1;
            end else begin
                m_k[i]++;
                emit(i);
            end
        end else begin
            m_ph[i] = 0;
        end
    endtask

    always @(posedge clk)
        for (int i = 0; i < 3; i++) model_step(i);

    // compare + observation process
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_wren", i), 32'(wren_o[i]), 32'(e_wren[i]));
                chk($sformatf("u%0d_addr", i), 32'(addr_o[i]), 32'(e_addr[i]));
                chk($sformatf("u%0d_data", i), 32'(data_o[i]), 32'(e_data[i]));
                chk($sformatf("u%0d_busy", i), 32'(busy_o[i]), 32'(e_busy[i]));
                chk($sformatf("u%0d_done", i), 32'(done_o[i]), 32'(e_done[i]));
                chk($sformatf("u%0d_hold", i), 32'(hold_o[i]), 32'(e_hold[i]));
                if (wren_o[i] === 1'b1) begin
                    nwr[i]++;
                    if (data_o[i] === 1'b1) nones[i]++;
                    if (addr_o[i] < 24'd8)  first8[i][addr_o[i][2:0]] = data_o[i];
                    if (addr_o[i] < 24'd64) mask[i][addr_o[i][5:0]] = data_o[i];
                end
                if (done_o[i] === 1'b1) ndone[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_stats(input int i);
        nwr[i] = 0; nones[i] = 0; ndone[i] = 0; first8[i] = '0; mask[i] = '0; m_ones[i] = 0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (done_o[i] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_o[i] !== 1'b1) begin
            errors++;
            $display("FAIL u%0d_done_timeout: no done within %0d cycles", i, budget);
        end
        tick();
    endtask

    task automatic do_fill(input int i, input logic [1:0] md, input logic sl,
                           input logic [15:0] sd, input int budget);
        clr_stats(i);
        start_i[i] = 1'b1; mode_i[i] = md; sl_i[i] = sl; seed_i[i] = sd;
        tick();
        start_i[i] = 1'b0; sl_i[i] = 1'b0;
        mode_i[i] = 2'($urandom);   // must be ignored once latched
        wait_done(i, budget);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_i[i] = 1'b1; start_i[i] = 1'b0; mode_i[i] = 2'd0;
            sl_i[i] = 1'b0; seed_i[i] = 16'h0;
            clr_stats(i);
        end
        tick();
        chk_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) rst_i[i] = 1'b0;   // now in cycle r+1
        // auto start: nothing in r+1, first write at addr 0 in r+2
        @(negedge clk);
        chk("auto_r1_wren", 32'(wren_o[2]), 32'd0);
        @(negedge clk);
        chk("auto_r2_wren", 32'(wren_o[2]), 32'd1);
        chk("auto_r2_addr", 32'(addr_o[2]), 32'd0);
        wait_done(2, 1300);
        chk("auto_first8", 32'(first8[2]), 32'h64);
        chk("auto_nwr", 32'(nwr[2]), 32'd1200);
        chk("auto_ones", 32'(nones[2]), 32'(m_ones[2]));

        // clear on 4x3, exact cycle timing
        clr_stats(0);
        start_i[0] = 1'b1; mode_i[0] = 2'd0;
        tick();
        start_i[0] = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk($sformatf("clr_done_c%0d", c), 32'(done_o[0]), 32'(c == 13));
            chk($sformatf("clr_busy_c%0d", c), 32'(busy_o[0]), 32'(c <= 12));
            if (c == 1)  chk("clr_addr_first", 32'(addr_o[0]), 32'd0);
            if (c == 12) chk("clr_addr_last", 32'(addr_o[0]), 32'd11);
        end
        tick();
        chk("clr_nwr", 32'(nwr[0]), 32'd12);
        chk("clr_ones", 32'(nones[0]), 32'd0);

        do_fill(0, 2'd2, 1'b0, 16'h0, 40);
        chk("dens256_ones", 32'(nones[0]), 32'd12);
        do_fill(0, 2'd3, 1'b0, 16'h0, 40);
        chk("mode3_ones", 32'(nones[0]), 32'd0);
        do_fill(0, 2'd1, 1'b0, 16'h0, 40);
        chk("glider4x3_mask", 32'(mask[0][11:0]), 32'h840);

        // glider on 5x5 with start pulses mid-fill and in the done cycle
        clr_stats(1);
        start_i[1] = 1'b1; mode_i[1] = 2'd1;
        tick();
        start_i[1] = 1'b0;
        repeat (10) tick();
        start_i[1] = 1'b1; mode_i[1] = 2'd2;
        tick();
        start_i[1] = 1'b0;
        begin
            int n;
            n = 0;
            while (done_o[1] !== 1'b1 && n < 40) begin tick(); n++; end
            chk("glider_done_seen", 32'(done_o[1]), 32'd1);
        end
        start_i[1] = 1'b1;   // sampled in the done cycle
        tick();
        start_i[1] = 1'b0;
        repeat (40) tick();
        chk("glider_nwr", 32'(nwr[1]), 32'd25);
        chk("glider_mask", 32'(mask[1][24:0]), 32'h72080);
        chk("glider_ndone", 32'(ndone[1]), 32'd1);
        do_fill(1, 2'd2, 1'b1, 16'h1234, 40);
        chk("dens0_ones", 32'(nones[1]), 32'd0);
        chk("dens0_nwr", 32'(nwr[1]), 32'd25);

        // seed 1 together with start
        do_fill(2, 2'd2, 1'b1, 16'h0001, 1300);
        chk("seed1_first8", 32'(first8[2]), 32'h0F);
        chk("seed1_ones", 32'(nones[2]), 32'(m_ones[2]));
        chk("seed1_nwr", 32'(nwr[2]), 32'd1200);

        // zero seed maps to SEED
        sl_i[2] = 1'b1; seed_i[2] = 16'h0;
        tick();
        sl_i[2] = 1'b0;
        do_fill(2, 2'd2, 1'b0, 16'h0, 1300);
        chk("seed0_first8", 32'(first8[2]), 32'h64);

        // reset at write 500, then auto refill from SEED
        start_i[2] = 1'b1; mode_i[2] = 2'd0;
        tick();
        start_i[2] = 1'b0;
        begin
            int n;
            n = 0;
            while (!(wren_o[2] === 1'b1 && addr_o[2] == 24'd500) && n < 600) begin tick(); n++; end
            chk("rst_reach500", 32'(addr_o[2]), 32'd500);
        end
        rst_i[2] = 1'b1;
        tick();
        rst_i[2] = 1'b0;
        clr_stats(2);
        @(negedge clk);
        chk("rst_wren0", 32'(wren_o[2]), 32'd0);
        chk("rst_busy0", 32'(busy_o[2]), 32'd0);
        chk("rst_hold0", 32'(hold_o[2]), 32'd0);
        chk("rst_addr0", 32'(addr_o[2]), 32'd0);
        @(negedge clk);
        chk("rst_refill_wren", 32'(wren_o[2]), 32'd1);
        chk("rst_refill_addr", 32'(addr_o[2]), 32'd0);
        wait_done(2, 1300);
        chk("rst_refill_first8", 32'(first8[2]), 32'h64);
        chk("rst_refill_nwr", 32'(nwr[2]), 32'd1200);

        // randomized fills with input noise while busy
        for (int r = 0; r < 3; r++) begin
            int n;
            clr_stats(2);
            start_i[2] = 1'b1; mode_i[2] = 2'($urandom_range(0, 3));
            sl_i[2] = 1'($urandom); seed_i[2] = 16'($urandom);
            tick();
            n = 0;
            while (done_o[2] !== 1'b1 && n < 1300) begin
                start_i[2] = 1'($urandom); sl_i[2] = 1'($urandom);
                mode_i[2] = 2'($urandom); seed_i[2] = 16'($urandom);
                tick();
                n++;
            end
            chk($sformatf("rand%0d_done_seen", r), 32'(done_o[2]), 32'd1);
            tick();
            start_i[2] = 1'b0; sl_i[2] = 1'b0;
            repeat (3) tick();
            chk($sformatf("rand%0d_ones", r), 32'(nones[2]), 32'(m_ones[2]));
            chk($sformatf("rand%0d_nwr", r), 32'(nwr[2]), 32'd1200);
            chk($sformatf("rand%0d_ndone", r), 32'(ndone[2]), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
